// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake plus FIFO write port seen by fifo_wr_arbiter.
// The arbiter attaches as master; the producers and the FIFO attach as slave.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ-1:0]        in_last;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_ready;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic                      fifo_full;
    logic [IDW-1:0]            grant_id;
    logic                      burst_active;
    logic                      timeout_err;

    modport master (
        input  in_valid, in_last, in_data, fifo_full,
        output in_ready, fifo_wr_en, fifo_wr_data, grant_id, burst_active, timeout_err
    );

    modport slave (
        output in_valid, in_last, in_data, fifo_full,
        input  in_ready, fifo_wr_en, fifo_wr_data, grant_id, burst_active, timeout_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking write arbiter sharing one FIFO write port among producers.
// Handshake is zero-latency: grant and write data are combinational from registered state.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master arb_if
);
    // state   | meaning
    // S_IDLE  | no owner; each cycle pick the next valid producer after rr_q
    // S_BURST | owner_q holds the port until last beat, BURST_MAX beats or timeout
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(BURST_MAX + 1);
    localparam int ICW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [BCW-1:0] beat_q, beat_d;
    logic [ICW-1:0] idle_q, idle_d;
    logic           burst_q, burst_d;
    logic           terr_q, terr_d;

    logic [IDW-1:0]     idx;
    logic [IDW-1:0]     sel_idle;
    logic [IDW-1:0]     pick;
    logic               found;
    logic               cand;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] ready;
    logic               pick_valid;
    logic               pick_last;
    logic               xfer;
    logic [DATA_W-1:0]  wr_data;

    always_comb begin
        idx      = rr_q;
        sel_idle = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && arb_if.in_valid[idx]) begin
                found    = 1'b1;
                sel_idle = idx;
            end
        end
        pick    = (state_q == S_BURST) ? owner_q : sel_idle;
        cand    = (state_q == S_BURST) || found;
        pick_oh = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDW'(i)) begin
                pick_oh[i] = 1'b1;
                wr_data    = arb_if.in_data[i*DATA_W +: DATA_W];
            end
        end
        pick_valid = |(arb_if.in_valid & pick_oh);
        pick_last  = |(arb_if.in_last & pick_oh);
        // reset gating keeps ready low the instant rst_n falls, not just after the flops clear
        ready      = (rst_n && cand && !arb_if.fifo_full) ? pick_oh : '0;
        xfer       = |(ready & arb_if.in_valid);
    end

    assign arb_if.in_ready     = ready;
    assign arb_if.fifo_wr_en   = xfer;
    assign arb_if.fifo_wr_data = wr_data;
    assign arb_if.grant_id     = grant_q;
    assign arb_if.burst_active = burst_q;
    assign arb_if.timeout_err  = terr_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        idle_d  = idle_q;
        terr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    grant_d = pick;
                    if (pick_last || BURST_MAX == 1) begin
                        rr_d = pick;
                    end else begin
                        state_d = S_BURST;
                        owner_d = pick;
                        beat_d  = BCW'(1);
                        idle_d  = '0;
                    end
                end
            end
            S_BURST: begin
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                    idle_d = '0;
                    if (pick_last || beat_q == BCW'(BURST_MAX - 1)) begin
                        state_d = S_IDLE;
                        rr_d    = owner_q;
                    end
                end else if (pick_valid) begin
                    idle_d = '0;
                end else if (!arb_if.fifo_full) begin
                    // full cycles are not the owner's fault, so they neither count nor clear
                    if (idle_q == ICW'(TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        rr_d    = owner_q;
                        terr_d  = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        burst_d = (state_d == S_BURST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= IDW'(NUM_REQ - 1);
            owner_q <= '0;
            grant_q <= '0;
            beat_q  <= '0;
            idle_q  <= '0;
            burst_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
            burst_q <= burst_d;
            terr_q  <= terr_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer beat queues, a 512-deep FIFO occupancy model,
// and a per-cycle reference model of the arbitration rules.
module tb_fifo_wr_arbiter;
    localparam int N = 4, DW = 8, BM = 16, TO = 32, DEPTH = 512, QD = 2048;

    logic clk = 1'b0;
    logic rst_n;
    logic fifo_rd;
    always #10 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // producer beat queues {last, data}; main pushes at tail, the checker pops on transfer
    logic [8:0] mem [N][QD];
    int head [N];
    int tail [N];
    initial for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

    task automatic push(input int p, input logic [7:0] d, input logic l);
        mem[p][tail[p]] = {l, d};
        tail[p]++;
    endtask

    function automatic logic all_empty();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    always begin
        logic [N-1:0] vv, ll;
        logic [N*DW-1:0] dd;
        vv = '0; ll = '0; dd = '0;
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) begin
                vv[i] = 1'b1;
                ll[i] = mem[i][head[i]][8];
                dd[i*DW +: DW] = mem[i][head[i]][7:0];
            end
        end
        bus.in_valid = vv;
        bus.in_last  = ll;
        bus.in_data  = dd;
        @(posedge clk); #4;
    end

    // FIFO occupancy: full is registered, set on the edge of the filling write
    int   fcnt = 0;
    logic wr_s = 1'b0;
    logic rd_s = 1'b0;
    always begin
        int n;
        bus.fifo_full = (fcnt >= DEPTH);
        @(posedge clk); #1;
        n = fcnt;
        if (wr_s) begin
            check("fifo_no_overflow", 32'(fcnt < DEPTH), 1);
            n++;
        end
        if (rd_s && fcnt > 0) n--;
        fcnt = n;
    end

    // reference model state
    int m_owner = -1, m_last = N - 1, m_beats = 0, m_idle = 0;
    int m_grant = 0, m_busy = 0, m_terr = 0;
    int ncyc = 0, n_busy = 0, n_terr = 0;
    int xid [$];
    int xcyc [$];
    logic [7:0] xdata [$];

    always @(negedge clk) begin
        logic [N-1:0] v, l, er, ar;
        logic full, ew;
        logic [7:0] ed;
        int cand, who;
        ncyc++;
        v = bus.in_valid; l = bus.in_last; full = bus.fifo_full;
        if (bus.burst_active) n_busy++;
        if (bus.timeout_err) n_terr++;
        if (!rst_n) begin
            m_owner = -1; m_last = N - 1; m_beats = 0; m_idle = 0;
            m_grant = 0; m_busy = 0; m_terr = 0;
            check("rst_ready", 32'(bus.in_ready), 0);
            check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
            check("rst_grant", 32'(bus.grant_id), 0);
            check("rst_busy", 32'(bus.burst_active), 0);
            wr_s = 1'b0;
            rd_s = fifo_rd;
        end else begin
            check("grant_id", 32'(bus.grant_id), 32'(m_grant));
            check("burst_active", 32'(bus.burst_active), 32'(m_busy));
            check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
            cand = -1;
            if (m_owner >= 0) cand = m_owner;
            else for (int j = 1; j <= N; j++)
                if (cand < 0 && v[(m_last + j) % N]) cand = (m_last + j) % N;
            er = '0;
            if (cand >= 0 && !full) er[cand] = 1'b1;
            ew = |(er & v);
            ed = (cand >= 0) ? bus.in_data[cand*DW +: DW] : 8'h00;
            check("in_ready", 32'(bus.in_ready), 32'(er));
            check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(ew));
            if (ew) check("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(ed));
            ar = bus.in_ready & v;
            who = -1;
            for (int i = N - 1; i >= 0; i--) if (ar[i]) who = i;
            if (who >= 0) begin
                xid.push_back(who);
                xdata.push_back(bus.in_data[who*DW +: DW]);
                xcyc.push_back(ncyc);
                head[who]++;
            end
            m_terr = 0;
            if (ew) begin
                if (m_owner < 0) begin
                    m_grant = cand;
                    if (l[cand] || BM == 1) m_last = cand;
                    else begin m_owner = cand; m_beats = 1; m_idle = 0; end
                end else begin
                    m_beats++;
                    m_idle = 0;
                    if (l[cand] || m_beats == BM) begin m_last = m_owner; m_owner = -1; end
                end
            end else if (m_owner >= 0) begin
                if (v[m_owner]) m_idle = 0;
                else if (!full) begin
                    m_idle++;
                    if (m_idle == TO) begin m_last = m_owner; m_owner = -1; m_terr = 1; end
                end
            end
            m_busy = (m_owner >= 0) ? 1 : 0;
            wr_s = bus.fifo_wr_en;
            rd_s = fifo_rd;
        end
    end

    task automatic sync();
        @(posedge clk); #2;
    endtask

    task automatic run_until_empty(input int budget, output int cyc);
        cyc = 0;
        do begin sync(); cyc++; end while (!all_empty() && cyc < budget);
        check("drain_in_budget", 32'(all_empty()), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, cyc, nb0, nt0;
        int e1 [6];
        logic [7:0] kb;
        bit data_ok;
        e1 = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0;
        fifo_rd = 1'b1;

        // reset state with every producer requesting, then round-robin single beats
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 3; k++) push(p, 8'(16 * p + k), 1'b1);
        sync(); sync();
        check("reset_ready_low", 32'(bus.in_ready), 0);
        check("reset_wr_en_low", 32'(bus.fifo_wr_en), 0);
        check("reset_timeout_err", 32'(bus.timeout_err), 0);
        b = xid.size();
        rst_n = 1'b1;
        run_until_empty(40, cyc);
        check("t1_continuous_cycles", cyc, 12);
        for (int k = 0; k < 6; k++) check("t1_grant_order", xid[b + k], e1[k]);
        check("t1_data5", 32'(xdata[b + 5]), 32'h11);

        // producer 2 burst of 5 while 0 and 1 wait
        b = xid.size(); nb0 = n_busy;
        for (int k = 0; k < 5; k++) push(2, 8'(8'hA0 + k), k == 4);
        sync();
        push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1);
        push(1, 8'h11, 1'b1); push(1, 8'h12, 1'b1);
        run_until_empty(40, cyc);
        for (int k = 0; k < 5; k++) check("t2_burst_data", 32'(xdata[b + k]), 32'(8'hA0 + k));
        check("t2_busy_cycles", n_busy - nb0, 4);
        check("t2_next_grant", xid[b + 5], 0);

        // 20 beats from producer 1 split at BURST_MAX
        b = xid.size();
        for (int k = 0; k < 20; k++) push(1, 8'(8'h40 + k), k == 19);
        sync();
        push(2, 8'hC2, 1'b1); push(0, 8'hC0, 1'b1);
        run_until_empty(80, cyc);
        check("t3_beat16_owner", xid[b + 15], 1);
        check("t3_after_limit_p2", xid[b + 16], 2);
        check("t3_after_limit_p0", xid[b + 17], 0);
        check("t3_resume_p1", xid[b + 18], 1);
        check("t3_resume_data", 32'(xdata[b + 18]), 32'h50);
        check("t3_count", xid.size() - b, 22);

        // fill the FIFO, then free exactly one slot
        repeat (2) sync();
        fifo_rd = 1'b0;
        b = xid.size();
        for (int k = 0; k < 520; k++) push(0, 8'(k), 1'b1);
        cyc = 0;
        while (!bus.fifo_full && cyc < 700) begin sync(); cyc++; end
        check("t4_full_seen", 32'(bus.fifo_full), 1);
        sync(); sync();
        check("t4_fill_count", xid.size() - b, 512);
        check("t4_full_wr_en", 32'(bus.fifo_wr_en), 0);
        check("t4_full_ready", 32'(bus.in_ready), 0);
        fifo_rd = 1'b1; sync(); fifo_rd = 1'b0;
        repeat (4) sync();
        check("t4_one_more", xid.size() - b, 513);
        check("t4_pending", tail[0] - head[0], 7);
        fifo_rd = 1'b1;
        run_until_empty(100, cyc);
        check("t4_total", xid.size() - b, 520);
        data_ok = 1'b1;
        for (int k = 0; k < 520; k++) begin
            kb = 8'(k);
            if (xdata[b + k] !== kb) data_ok = 1'b0;
        end
        check("t4_data_order", 32'(data_ok), 1);

        // producer 3 stalls mid-burst
        b = xid.size(); nt0 = n_terr;
        push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b0); push(3, 8'hD2, 1'b0);
        sync();
        push(0, 8'hB0, 1'b1);
        run_until_empty(100, cyc);
        check("t5_timeout_pulses", n_terr - nt0, 1);
        check("t5_next_grant", xid[b + 3], 0);
        check("t5_release_gap", xcyc[b + 3] - xcyc[b + 2], 33);
        check("t5_busy_low", 32'(bus.burst_active), 0);

        // asynchronous reset in the middle of a burst
        b = xid.size();
        for (int k = 0; k < 6; k++) push(1, 8'(8'hE0 + k), k == 5);
        push(3, 8'h3F, 1'b1);
        sync(); sync();
        check("t6_pre_busy", 32'(bus.burst_active), 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_ready", 32'(bus.in_ready), 0);
        check("t6_async_wr_en", 32'(bus.fifo_wr_en), 0);
        check("t6_async_busy", 32'(bus.burst_active), 0);
        check("t6_async_grant", 32'(bus.grant_id), 0);
        sync();
        push(0, 8'h0F, 1'b1);
        sync();
        rst_n = 1'b1;
        run_until_empty(60, cyc);
        check("t6_first_after_reset", xid[b + 2], 0);
        check("t6_resume_data", 32'(xdata[b + 3]), 32'hE2);
        check("t6_last_grant", xid[b + 7], 3);
        check("t6_count", xid.size() - b, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
